// File: rtl/r22sdf_reorder_pkg.sv
// Shared types for the R22SDF output reorder buffer: complex sample type,
// read-side FSM state encoding and the bit-reversal helper.
package R22SdfDefines;

  localparam int CPLX_W    = 16;
  localparam int MAX_LOG2N = 16;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } Cplx_t;

  typedef enum logic [1:0] {IDLE, FETCH, SHOW} RdState_t;

  // Reverse the low w bits of v; bits above w come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] v, input int w);
    logic [MAX_LOG2N-1:0] rev;
    rev = {<<{v}};
    return rev >> (MAX_LOG2N - w);
  endfunction

endpackage

// File: rtl/r22sdf_reorder_if.sv
// Stream bundle around the reorder buffer: bit-reversed input stream in,
// natural-order output stream out. With R22SDF_REORDER_SOP_EOP_EN defined the
// bundle also carries out_sop/out_eop frame markers.
//
// Handshake: a sample moves on a rising clk edge exactly when valid & ready
// are both high. A source must hold valid and its payload stable until that
// edge; ready may change freely and never depends combinationally on valid.
interface r22sdf_reorder_if #(parameter int LOG2N = 6);
  import R22SdfDefines::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  Cplx_t            in_data;
  logic             out_valid;
  logic             out_ready;
  Cplx_t            out_data;
  logic [LOG2N-1:0] out_index;
`ifdef R22SDF_REORDER_SOP_EOP_EN
  logic             out_sop;
  logic             out_eop;

  modport master (output in_valid, in_sof, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_index, out_sop, out_eop);
  modport slave  (input  in_valid, in_sof, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_index, out_sop, out_eop);
`else
  modport master (output in_valid, in_sof, in_data, out_ready,
                  input  in_ready, out_valid, out_data, out_index);
  modport slave  (input  in_valid, in_sof, in_data, out_ready,
                  output in_ready, out_valid, out_data, out_index);
`endif

endinterface

// File: rtl/r22sdf_reorder_bank.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// The read register only loads when re_i is high, so it doubles as the
// held output register of the reorder buffer.
module r22sdf_reorder_bank
  import R22SdfDefines::*;
#(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  Cplx_t         wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output Cplx_t         rdata_o
);

  Cplx_t mem [0:(1<<AW)-1];
  Cplx_t rdata_q;

  // Write port: storage carries no reset, contents are only trusted once written.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Read port: loads on demand, holds otherwise, clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/r22sdf_reorder.sv
// R22SDF output reorder buffer. Frames arrive in bit-reversed order and are
// written to a ping-pong RAM at bit-reversed addresses; the read side streams
// each completed frame out in natural order 0..N-1.
// Optional feature macro: R22SDF_REORDER_SOP_EOP_EN adds out_sop/out_eop.
// Both ping-pong banks live in one RAM of depth 2N with the bank bit as MSB.
module r22sdf_reorder
  import R22SdfDefines::*;
#(
  parameter int LOG2N = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  r22sdf_reorder_if.slave      bus,
  output RdState_t             dbg_state_o
);

  localparam int               N    = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  // Write side
  logic             ready_en_q;
  logic [1:0]       full_q, full_d;
  logic             wbank_q, wbank_d;
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic [LOG2N-1:0] wpos, waddr;
  logic             wr_en, set_full;

  // Read side
  RdState_t         state_q, state_d;
  logic             rbank_q, rbank_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic [LOG2N-1:0] rd_idx;
  logic             rd_en, clr_full;
  Cplx_t            rdata;

  // in_ready is held low through reset and for the first edge after it.
  assign bus.in_ready = ready_en_q & ~full_q[wbank_q];
  assign wr_en        = bus.in_valid & bus.in_ready;

  // Write address generation; in_sof restarts the frame at position 0.
  always_comb begin
    wpos     = bus.in_sof ? '0 : wcnt_q;
    waddr    = LOG2N'(bitrev(MAX_LOG2N'(wpos), LOG2N));
    set_full = 1'b0;
    wcnt_d   = wcnt_q;
    wbank_d  = wbank_q;
    if (wr_en) begin
      if (wpos == LAST) begin
        set_full = 1'b1;
        wcnt_d   = '0;
        wbank_d  = ~wbank_q;
      end else begin
        wcnt_d   = wpos + 1'b1;
      end
    end
  end

  // Bank-full flags; writer and reader always touch different banks.
  always_comb begin
    full_d = full_q;
    if (set_full) full_d[wbank_q] = 1'b1;
    if (clr_full) full_d[rbank_q] = 1'b0;
  end

  // Write-side state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
      full_q     <= '0;
      wbank_q    <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      ready_en_q <= 1'b1;
      full_q     <= full_d;
      wbank_q    <= wbank_d;
      wcnt_q     <= wcnt_d;
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rbank_q <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rbank_q <= rbank_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // Read FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (full_q[rbank_q]) state_d = FETCH;
      FETCH:   state_d = SHOW;
      SHOW:    if (bus.out_ready && rcnt_q == LAST) state_d = full_q[~rbank_q] ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read FSM outputs: RAM read requests, counter/bank advance, bank release.
  // A read is issued on every edge that must change the shown sample, so a
  // ready sink sees one sample per clock with no bubble inside a frame.
  always_comb begin
    rd_en    = 1'b0;
    rd_idx   = rcnt_q;
    rcnt_d   = rcnt_q;
    rbank_d  = rbank_q;
    clr_full = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          rd_en  = 1'b1;
          rd_idx = '0;
        end
      end
      SHOW: begin
        if (bus.out_ready) begin
          if (rcnt_q != LAST) begin
            rcnt_d = rcnt_q + 1'b1;
            rd_en  = 1'b1;
            rd_idx = rcnt_d;
          end else begin
            clr_full = 1'b1;
            rbank_d  = ~rbank_q;
            rcnt_d   = '0;
            if (full_q[~rbank_q]) begin
              rd_en  = 1'b1;
              rd_idx = '0;
            end
          end
        end
      end
      default: ;
    endcase
  end

  r22sdf_reorder_bank #(.AW(LOG2N + 1)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_en),
    .waddr_i ({wbank_q, waddr}),
    .wdata_i (bus.in_data),
    .re_i    (rd_en),
    .raddr_i ({rbank_d, rd_idx}),
    .rdata_o (rdata)
  );

  assign bus.out_valid = (state_q == SHOW);
  assign bus.out_index = rcnt_q;
  assign bus.out_data  = rdata;
  assign dbg_state_o   = state_q;

`ifdef R22SDF_REORDER_SOP_EOP_EN
  logic sop_q, eop_q;

  // Frame markers load together with the RAM read so they track out_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sop_q <= 1'b0;
      eop_q <= 1'b0;
    end else if (rd_en) begin
      sop_q <= (rd_idx == '0);
      eop_q <= (rd_idx == LAST);
    end
  end

  assign bus.out_sop = sop_q;
  assign bus.out_eop = eop_q;
`endif

endmodule
